// File: rtl/ewrapper_emesh_pkg.sv
// Shared packet layout, arbitration state type and pack/unpack helpers
// for the eMesh transmit-port arbiter.
package ewrapper_emesh_pkg;

    localparam int PKT_W       = 103;
    localparam int BURST_CNT_W = 8;

    localparam int DATA_LSB     = 0;
    localparam int DATA_W       = 32;
    localparam int SRCADDR_LSB  = 32;
    localparam int SRCADDR_W    = 32;
    localparam int DSTADDR_LSB  = 64;
    localparam int DSTADDR_W    = 32;
    localparam int CTRLMODE_LSB = 96;
    localparam int CTRLMODE_W   = 4;
    localparam int DATAMODE_LSB = 100;
    localparam int DATAMODE_W   = 2;
    localparam int WRITE_LSB    = 102;

    typedef struct packed {
        logic        write;
        logic [1:0]  datamode;
        logic [3:0]  ctrlmode;
        logic [31:0] dstaddr;
        logic [31:0] srcaddr;
        logic [31:0] data;
    } emesh_pkt_t;

    // Arbitration state, kept as one struct so it can be probed as a unit.
    typedef struct packed {
        logic                   prio;
        logic                   owner;
        logic [BURST_CNT_W-1:0] burst_cnt;
        logic                   last_wr;
    } arb_state_t;

    function automatic logic [PKT_W-1:0] pkt_pack(input emesh_pkt_t p);
        logic [PKT_W-1:0] v;
        v = '0;
        v[WRITE_LSB]                     = p.write;
        v[DATAMODE_LSB +: DATAMODE_W]    = p.datamode;
        v[CTRLMODE_LSB +: CTRLMODE_W]    = p.ctrlmode;
        v[DSTADDR_LSB  +: DSTADDR_W]     = p.dstaddr;
        v[SRCADDR_LSB  +: SRCADDR_W]     = p.srcaddr;
        v[DATA_LSB     +: DATA_W]        = p.data;
        return v;
    endfunction

    function automatic emesh_pkt_t pkt_unpack(input logic [PKT_W-1:0] v);
        emesh_pkt_t p;
        p.write    = v[WRITE_LSB];
        p.datamode = v[DATAMODE_LSB +: DATAMODE_W];
        p.ctrlmode = v[CTRLMODE_LSB +: CTRLMODE_W];
        p.dstaddr  = v[DSTADDR_LSB  +: DSTADDR_W];
        p.srcaddr  = v[SRCADDR_LSB  +: SRCADDR_W];
        p.data     = v[DATA_LSB     +: DATA_W];
        return p;
    endfunction

endpackage

// File: rtl/ewrapper_emesh_fifo2.sv
// Two-entry packet FIFO with registered full/empty; pushes while full are
// dropped and pops while empty are ignored.
module ewrapper_emesh_fifo2
    import ewrapper_emesh_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [PKT_W-1:0] din,
    input  logic             pop,
    output logic [PKT_W-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [PKT_W-1:0] mem_q [2];
    logic [PKT_W-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == 2'd2);
        empty_d = (count_d == 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/ewrapper_emesh_arb.sv
// Round-robin arbiter sharing the eMesh transmit port between two buffered
// requesters, keeping same-owner write runs together up to BURST_MAX.
module ewrapper_emesh_arb
    import ewrapper_emesh_pkg::*;
#(
    parameter int BURST_MAX = 8
)(
    input  logic        emesh_clk_inb,
    input  logic        reset,
    input  logic        req0_access,
    input  logic        req0_write,
    input  logic [1:0]  req0_datamode,
    input  logic [3:0]  req0_ctrlmode,
    input  logic [31:0] req0_dstaddr,
    input  logic [31:0] req0_srcaddr,
    input  logic [31:0] req0_data,
    input  logic        req1_access,
    input  logic        req1_write,
    input  logic [1:0]  req1_datamode,
    input  logic [3:0]  req1_ctrlmode,
    input  logic [31:0] req1_dstaddr,
    input  logic [31:0] req1_srcaddr,
    input  logic [31:0] req1_data,
    output logic        req0_wait,
    output logic        req1_wait,
    input  logic        emesh_wr_wait_inb,
    input  logic        emesh_rd_wait_inb,
    output logic        emesh_access_outb,
    output logic        emesh_write_outb,
    output logic [1:0]  emesh_datamode_outb,
    output logic [3:0]  emesh_ctrlmode_outb,
    output logic [31:0] emesh_dstaddr_outb,
    output logic [31:0] emesh_srcaddr_outb,
    output logic [31:0] emesh_data_outb,
    output logic        arb_owner
);

    localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(BURST_MAX);
    localparam logic [BURST_CNT_W-1:0] CNT_ONE   = 1;

    // Handshake: a requester may strobe reqN_access only while reqN_wait is
    // low; the port strobes emesh_access_outb for exactly one cycle per
    // transaction and never waits on the transmitter after the strobe.
    logic [PKT_W-1:0] in_pkt   [2];
    logic [PKT_W-1:0] head_pkt [2];
    logic [1:0]       fifo_full, fifo_empty, pop, elig, head_wr;
    arb_state_t       st_q, st_d;
    logic [PKT_W-1:0] out_pkt_q, out_pkt_d;
    logic             access_q, access_d;
    logic             owner_out_q, owner_out_d;
    logic             grant, gnt_idx, locked;
    emesh_pkt_t       out_f;

    always_comb begin
        in_pkt[0] = pkt_pack('{write: req0_write, datamode: req0_datamode,
                               ctrlmode: req0_ctrlmode, dstaddr: req0_dstaddr,
                               srcaddr: req0_srcaddr, data: req0_data});
        in_pkt[1] = pkt_pack('{write: req1_write, datamode: req1_datamode,
                               ctrlmode: req1_ctrlmode, dstaddr: req1_dstaddr,
                               srcaddr: req1_srcaddr, data: req1_data});
    end

    ewrapper_emesh_fifo2 u_fifo0 (
        .clk(emesh_clk_inb), .rst(reset), .push(req0_access), .din(in_pkt[0]),
        .pop(pop[0]), .head(head_pkt[0]), .full(fifo_full[0]), .empty(fifo_empty[0])
    );

    ewrapper_emesh_fifo2 u_fifo1 (
        .clk(emesh_clk_inb), .rst(reset), .push(req1_access), .din(in_pkt[1]),
        .pop(pop[1]), .head(head_pkt[1]), .full(fifo_full[1]), .empty(fifo_empty[1])
    );

    // A blocked head only removes its own requester from the decision.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            head_wr[i] = head_pkt[i][WRITE_LSB];
            elig[i]    = !fifo_empty[i] &&
                         !(head_wr[i] ? emesh_wr_wait_inb : emesh_rd_wait_inb);
        end
        locked = st_q.last_wr && elig[st_q.owner] && head_wr[st_q.owner] &&
                 (st_q.burst_cnt < BURST_LIM);

        grant   = 1'b0;
        gnt_idx = 1'b0;
        if (locked) begin
            grant   = 1'b1;
            gnt_idx = st_q.owner;
        end else if (elig[st_q.prio]) begin
            grant   = 1'b1;
            gnt_idx = st_q.prio;
        end else if (elig[~st_q.prio]) begin
            grant   = 1'b1;
            gnt_idx = ~st_q.prio;
        end
        pop[0] = grant && !gnt_idx;
        pop[1] = grant && gnt_idx;

        st_d        = st_q;
        access_d    = 1'b0;
        out_pkt_d   = out_pkt_q;
        owner_out_d = owner_out_q;
        if (grant) begin
            access_d       = 1'b1;
            out_pkt_d      = head_pkt[gnt_idx];
            owner_out_d    = gnt_idx;
            st_d.prio      = ~gnt_idx;
            st_d.owner     = gnt_idx;
            st_d.last_wr   = head_wr[gnt_idx];
            st_d.burst_cnt = locked ? st_q.burst_cnt + CNT_ONE : CNT_ONE;
        end else begin
            st_d.last_wr = 1'b0;
        end
    end

    always_ff @(posedge emesh_clk_inb or posedge reset) begin
        if (reset) begin
            st_q        <= '0;
            access_q    <= 1'b0;
            out_pkt_q   <= '0;
            owner_out_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            access_q    <= access_d;
            out_pkt_q   <= out_pkt_d;
            owner_out_q <= owner_out_d;
        end
    end

    assign out_f               = pkt_unpack(out_pkt_q);
    assign emesh_access_outb   = access_q;
    assign emesh_write_outb    = out_f.write;
    assign emesh_datamode_outb = out_f.datamode;
    assign emesh_ctrlmode_outb = out_f.ctrlmode;
    assign emesh_dstaddr_outb  = out_f.dstaddr;
    assign emesh_srcaddr_outb  = out_f.srcaddr;
    assign emesh_data_outb     = out_f.data;
    assign arb_owner           = owner_out_q;
    assign req0_wait           = fifo_full[0];
    assign req1_wait           = fifo_full[1];

endmodule

// File: tb/tb_ewrapper_emesh_arb.sv
// Scoreboard bench for ewrapper_emesh_arb: u_dut_a uses BURST_MAX=4,
// u_dut_b uses BURST_MAX=1; sel_b routes the request strobes to one of them.
module tb_ewrapper_emesh_arb;
    import ewrapper_emesh_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        acc0, acc1, sel_b;
    logic        wr0, wr1;
    logic [1:0]  dm0, dm1;
    logic [3:0]  cm0, cm1;
    logic [31:0] da0, sa0, d0, da1, sa1, d1;
    logic        wr_wait, rd_wait;

    logic        a_wait0, a_wait1, a_access, a_write, a_owner;
    logic [1:0]  a_dm;
    logic [3:0]  a_cm;
    logic [31:0] a_da, a_sa, a_d;
    logic        b_wait0, b_wait1, b_access, b_write, b_owner;
    logic [1:0]  b_dm;
    logic [3:0]  b_cm;
    logic [31:0] b_da, b_sa, b_d;

    logic [PKT_W-1:0] exp0_q[$];
    logic [PKT_W-1:0] exp1_q[$];
    logic             own_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_strobe = 0;
    int first0_cyc = -1;

    ewrapper_emesh_arb #(.BURST_MAX(4)) u_dut_a (
        .emesh_clk_inb(clk), .reset(rst),
        .req0_access(acc0 && !sel_b), .req0_write(wr0), .req0_datamode(dm0),
        .req0_ctrlmode(cm0), .req0_dstaddr(da0), .req0_srcaddr(sa0), .req0_data(d0),
        .req1_access(acc1 && !sel_b), .req1_write(wr1), .req1_datamode(dm1),
        .req1_ctrlmode(cm1), .req1_dstaddr(da1), .req1_srcaddr(sa1), .req1_data(d1),
        .req0_wait(a_wait0), .req1_wait(a_wait1),
        .emesh_wr_wait_inb(wr_wait), .emesh_rd_wait_inb(rd_wait),
        .emesh_access_outb(a_access), .emesh_write_outb(a_write),
        .emesh_datamode_outb(a_dm), .emesh_ctrlmode_outb(a_cm),
        .emesh_dstaddr_outb(a_da), .emesh_srcaddr_outb(a_sa),
        .emesh_data_outb(a_d), .arb_owner(a_owner)
    );

    ewrapper_emesh_arb #(.BURST_MAX(1)) u_dut_b (
        .emesh_clk_inb(clk), .reset(rst),
        .req0_access(acc0 && sel_b), .req0_write(wr0), .req0_datamode(dm0),
        .req0_ctrlmode(cm0), .req0_dstaddr(da0), .req0_srcaddr(sa0), .req0_data(d0),
        .req1_access(acc1 && sel_b), .req1_write(wr1), .req1_datamode(dm1),
        .req1_ctrlmode(cm1), .req1_dstaddr(da1), .req1_srcaddr(sa1), .req1_data(d1),
        .req0_wait(b_wait0), .req1_wait(b_wait1),
        .emesh_wr_wait_inb(wr_wait), .emesh_rd_wait_inb(rd_wait),
        .emesh_access_outb(b_access), .emesh_write_outb(b_write),
        .emesh_datamode_outb(b_dm), .emesh_ctrlmode_outb(b_cm),
        .emesh_dstaddr_outb(b_da), .emesh_srcaddr_outb(b_sa),
        .emesh_data_outb(b_d), .arb_owner(b_owner)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- clock / cycle counter ----------------
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    task automatic score(input logic which, input logic own, input logic [PKT_W-1:0] pkt);
        logic             exp_own;
        logic [PKT_W-1:0] exp_pkt;
        n_strobe++;
        if (own == 1'b0 && first0_cyc < 0) first0_cyc = cyc;
        check("dut_select", which, sel_b);
        check("strobe_expected", own_q.size() != 0, 1'b1);
        if (own_q.size() == 0) return;
        exp_own = own_q.pop_front();
        check("arb_owner", own, exp_own);
        if (own == 1'b0) begin
            check("pkt0_avail", exp0_q.size() != 0, 1'b1);
            if (exp0_q.size() != 0) begin
                exp_pkt = exp0_q.pop_front();
                check("pkt0", pkt, exp_pkt);
            end
        end else begin
            check("pkt1_avail", exp1_q.size() != 0, 1'b1);
            if (exp1_q.size() != 0) begin
                exp_pkt = exp1_q.pop_front();
                check("pkt1", pkt, exp_pkt);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_access) score(1'b0, a_owner, {a_write, a_dm, a_cm, a_da, a_sa, a_d});
            if (b_access) score(1'b1, b_owner, {b_write, b_dm, b_cm, b_da, b_sa, b_d});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    task automatic put(input int r, input logic wr, input logic [31:0] da, input bit track);
        logic [PKT_W-1:0] p;
        p = {wr, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), da, $urandom, $urandom};
        if (r == 0) begin
            {wr0, dm0, cm0, da0, sa0, d0} = p;
            acc0 = 1'b1;
            if (track) exp0_q.push_back(p);
        end else begin
            {wr1, dm1, cm1, da1, sa1, d1} = p;
            acc1 = 1'b1;
            if (track) exp1_q.push_back(p);
        end
    endtask

    task automatic stream(input logic wr, input int n);
        int s0 = 0;
        int s1 = 0;
        int guard = 0;
        logic w0, w1;
        while ((s0 < n || s1 < n) && guard < 200) begin
            tick();
            guard++;
            w0 = sel_b ? b_wait0 : a_wait0;
            w1 = sel_b ? b_wait1 : a_wait1;
            if (s0 < n && !w0) begin put(0, wr, 32'h200 + 32'(s0 * 4), 1'b1); s0++; end
            if (s1 < n && !w1) begin put(1, wr, 32'h300 + 32'(s1 * 4), 1'b1); s1++; end
        end
        check("stream_issued", s0 + s1, 2 * n);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (own_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", own_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        exp0_q.delete();
        exp1_q.delete();
        own_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t_drop, snap;
        rst = 1'b1; sel_b = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        wr_wait = 1'b0; rd_wait = 1'b0;
        {wr0, dm0, cm0, da0, sa0, d0} = '0;
        {wr1, dm1, cm1, da1, sa1, d1} = '0;
        repeat (2) tick();

        check("rst_access", a_access, 1'b0);
        check("rst_owner", a_owner, 1'b0);
        check("rst_fields", {a_write, a_dm, a_cm, a_da, a_sa, a_d}, '0);
        check("rst_waits", {a_wait0, a_wait1}, 2'b00);
        rst = 1'b0;

        // single-requester write stream
        first0_cyc = -1;
        t0 = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) t0 = cyc;
            check("req0_wait_stream", a_wait0, 1'b0);
            put(0, 1'b1, 32'h100 + 32'(i * 8), 1'b1);
            own_q.push_back(1'b0);
        end
        drain(50);
        check("first_latency", 32'(first0_cyc - t0), 32'd2);

        // read alternation from reset
        do_reset();
        for (int i = 0; i < 16; i++) own_q.push_back(1'(i % 2));
        stream(1'b0, 8);
        drain(100);

        // write burst lock, BURST_MAX=4
        do_reset();
        for (int i = 0; i < 16; i++) own_q.push_back(1'((i / 4) % 2));
        stream(1'b1, 8);
        drain(100);

        // write burst lock, BURST_MAX=1
        sel_b = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) own_q.push_back(1'(i % 2));
        stream(1'b1, 8);
        drain(100);
        sel_b = 1'b0;

        // type blocking: writes held off by wr_wait, reads pass
        do_reset();
        first0_cyc = -1;
        own_q.push_back(1'b1); own_q.push_back(1'b1);
        own_q.push_back(1'b0); own_q.push_back(1'b0);
        tick();
        wr_wait = 1'b1;
        put(0, 1'b1, 32'h400, 1'b1);
        put(1, 1'b0, 32'h500, 1'b1);
        tick();
        put(0, 1'b1, 32'h404, 1'b1);
        put(1, 1'b0, 32'h504, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("req0_wait_blocked", a_wait0, 1'b1);
        end
        tick();
        wr_wait = 1'b0;
        t_drop = cyc;
        drain(50);
        check("write_after_wait_drop", 32'(first0_cyc - t_drop), 32'd1);

        // overflow: third access while full is dropped
        rd_wait = 1'b1;
        tick();
        put(1, 1'b0, 32'h600, 1'b1);
        tick();
        put(1, 1'b0, 32'h604, 1'b1);
        tick();
        check("req1_wait_full", a_wait1, 1'b1);
        put(1, 1'b0, 32'h608, 1'b0);
        tick();
        rd_wait = 1'b0;
        own_q.push_back(1'b1); own_q.push_back(1'b1);
        drain(50);

        // reset with both FIFOs full
        wr_wait = 1'b1; rd_wait = 1'b1;
        tick();
        put(0, 1'b1, 32'h700, 1'b0); put(1, 1'b1, 32'h800, 1'b0);
        tick();
        put(0, 1'b1, 32'h704, 1'b0); put(1, 1'b1, 32'h804, 1'b0);
        tick();
        check("full_waits", {a_wait0, a_wait1}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_access", a_access, 1'b0);
        check("async_rst_owner", a_owner, 1'b0);
        check("async_rst_fields", {a_write, a_dm, a_cm, a_da, a_sa, a_d}, '0);
        check("async_rst_waits", {a_wait0, a_wait1}, 2'b00);
        repeat (2) tick();
        rst = 1'b0;
        wr_wait = 1'b0; rd_wait = 1'b0;
        snap = n_strobe;
        repeat (6) tick();
        check("no_strobe_after_reset", n_strobe - snap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
